// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequences one registered MAC PE (oC = iA*iB + iC, 1-cycle
// latency) through a K-element unsigned dot product with a saturating
// 2*MAC_BW-bit accumulator fed back through iC.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   job_valid/job_ready       job descriptor handshake (job_len, job_bias)
//   op_valid/op_ready         operand pair handshake (op_a, op_b)
//   mac_a, mac_b, mac_c       combinational drive to MAC iA, iB, iC
//   mac_oc                    MAC oC (2*MAC_BW+4 bits)
//   res_valid/res_ready       result handshake (res_data, res_ovf)
//   busy                      high whenever the sequencer is not idle
module mac_seq_ctrl #(
  parameter int unsigned MAC_BW = 16,
  parameter int unsigned LEN_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    job_valid,
  output logic                    job_ready,
  input  logic [LEN_W-1:0]        job_len,
  input  logic [2*MAC_BW-1:0]     job_bias,
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic [MAC_BW-1:0]       op_a,
  input  logic [MAC_BW-1:0]       op_b,
  output logic [MAC_BW-1:0]       mac_a,
  output logic [MAC_BW-1:0]       mac_b,
  output logic [2*MAC_BW-1:0]     mac_c,
  input  logic [2*MAC_BW+3:0]     mac_oc,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [2*MAC_BW-1:0]     res_data,
  output logic                    res_ovf,
  output logic                    busy
);

  localparam int unsigned ACC_W = 2 * MAC_BW;
  localparam int unsigned OC_W  = ACC_W + 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state, state_d;
  logic [LEN_W-1:0]   remaining, remaining_d;
  logic               first, first_d;
  logic [ACC_W-1:0]   bias_q, bias_d;
  logic               ovf, ovf_d;
  logic               res_valid_d;
  logic [ACC_W-1:0]   res_data_d;
  logic               res_ovf_d;

  // Saturate the MAC output back to accumulator width.
  logic               clamp_c;
  logic [ACC_W-1:0]   sat_c;
  assign clamp_c = |mac_oc[OC_W-1:ACC_W];
  assign sat_c   = clamp_c ? {ACC_W{1'b1}} : mac_oc[ACC_W-1:0];

  // Next-state, datapath next values and MAC drive.
  always_comb begin
    state_d     = state;
    remaining_d = remaining;
    first_d     = first;
    bias_d      = bias_q;
    ovf_d       = ovf;
    res_valid_d = res_valid;
    res_data_d  = res_data;
    res_ovf_d   = res_ovf;
    mac_a       = '0;
    mac_b       = '0;
    mac_c       = '0;

    case (state)
      S_IDLE: begin
        if (job_valid) begin
          if (job_len != '0) begin
            remaining_d = job_len;
            bias_d      = job_bias;
            first_d     = 1'b1;
            ovf_d       = 1'b0;
            state_d     = S_RUN;
          end else begin
            res_data_d  = job_bias;
            res_ovf_d   = 1'b0;
            res_valid_d = 1'b1;
            state_d     = S_DONE;
          end
        end
      end

      S_RUN: begin
        // Stall cycles still feed the accumulator back: 0*0 + acc = acc.
        mac_c = first ? bias_q : sat_c;
        if (!first && clamp_c) begin
          ovf_d = 1'b1;
        end
        if (op_valid) begin
          mac_a       = op_a;
          mac_b       = op_b;
          remaining_d = remaining - LEN_W'(1);
          first_d     = 1'b0;
          if (remaining == LEN_W'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        res_data_d  = sat_c;
        res_ovf_d   = ovf | clamp_c;
        res_valid_d = 1'b1;
        state_d     = S_DONE;
      end

      S_DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; status flags registered from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      remaining <= '0;
      first     <= 1'b0;
      bias_q    <= '0;
      ovf       <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_ovf   <= 1'b0;
      job_ready <= 1'b1;
      op_ready  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      remaining <= remaining_d;
      first     <= first_d;
      bias_q    <= bias_d;
      ovf       <= ovf_d;
      res_valid <= res_valid_d;
      res_data  <= res_data_d;
      res_ovf   <= res_ovf_d;
      job_ready <= (state_d == S_IDLE);
      op_ready  <= (state_d == S_RUN);
      busy      <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Testbench for mac_seq_ctrl: directed vector table, a reset-mid-job
// sequence and randomized jobs checked against a saturating dot-product model.
module tb_mac_seq_ctrl;

  localparam int unsigned MAC_BW = 16;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned ACC_W  = 2 * MAC_BW;
  localparam int unsigned OC_W   = ACC_W + 4;

  logic                clk;
  logic                rst;
  logic                job_valid;
  logic                job_ready;
  logic [LEN_W-1:0]    job_len;
  logic [ACC_W-1:0]    job_bias;
  logic                op_valid;
  logic                op_ready;
  logic [MAC_BW-1:0]   op_a;
  logic [MAC_BW-1:0]   op_b;
  logic [MAC_BW-1:0]   mac_a;
  logic [MAC_BW-1:0]   mac_b;
  logic [ACC_W-1:0]    mac_c;
  logic [OC_W-1:0]     mac_oc;
  logic                res_valid;
  logic                res_ready;
  logic [ACC_W-1:0]    res_data;
  logic                res_ovf;
  logic                busy;

  int vectors     = 0;
  int miscompares = 0;

  mac_seq_ctrl #(.MAC_BW(MAC_BW), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .job_valid (job_valid),
    .job_ready (job_ready),
    .job_len   (job_len),
    .job_bias  (job_bias),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_c     (mac_c),
    .mac_oc    (mac_oc),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_ovf   (res_ovf),
    .busy      (busy)
  );

  // Registered MAC PE, reset together with the sequencer.
  always_ff @(posedge clk) begin
    if (rst) mac_oc <= '0;
    else     mac_oc <= OC_W'(mac_a) * OC_W'(mac_b) + OC_W'(mac_c);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]      len;
    logic [31:0]      bias;
    logic [7:0][15:0] a;
    logic [7:0][15:0] b;
    logic [3:0]       gap_pre;
    logic [3:0]       gap_mid;
    logic [3:0]       hold;
    logic [31:0]      exp_data;
    logic             exp_ovf;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int len, input logic [31:0] bias,
                              input logic [15:0] a0, input logic [15:0] b0,
                              input logic [15:0] a1, input logic [15:0] b1,
                              input logic [15:0] a2, input logic [15:0] b2,
                              input int gp, input int gm, input int hold,
                              input logic [31:0] ed, input logic eo);
    vec_t v;
    v = '0;
    v.len = 16'(len);
    v.bias = bias;
    v.a[0] = a0; v.b[0] = b0;
    v.a[1] = a1; v.b[1] = b1;
    v.a[2] = a2; v.b[2] = b2;
    v.gap_pre = 4'(gp);
    v.gap_mid = 4'(gm);
    v.hold = 4'(hold);
    v.exp_data = ed;
    v.exp_ovf = eo;
    return v;
  endfunction

  // Dot product with the running sum clamped to 32 bits after every term.
  function automatic void ref_model(input vec_t v, output logic [31:0] d, output logic o);
    logic [63:0] acc;
    acc = 64'(v.bias);
    o = 1'b0;
    for (int i = 0; i < int'(v.len); i++) begin
      acc = acc + 64'(v.a[i]) * 64'(v.b[i]);
      if (acc > 64'h0000_0000_FFFF_FFFF) begin
        acc = 64'h0000_0000_FFFF_FFFF;
        o = 1'b1;
      end
    end
    d = acc[31:0];
  endfunction

  // Runs one job end to end, checking handshakes, latency and result.
  task automatic run_job(input vec_t v);
    check("pre_job_ready", 64'(job_ready), 64'd1);
    check("pre_busy", 64'(busy), 64'd0);
    job_valid = 1'b1;
    job_len   = v.len;
    job_bias  = v.bias;
    tick();
    job_valid = 1'b0;
    if (v.len == '0) begin
      check("zl_res_valid", 64'(res_valid), 64'd1);
      check("zl_op_ready", 64'(op_ready), 64'd0);
    end else begin
      for (int i = 0; i < int'(v.len); i++) begin
        for (int g = 0; g < int'((i == 0) ? v.gap_pre : v.gap_mid); g++) begin
          check("stall_op_ready", 64'(op_ready), 64'd1);
          tick();
        end
        op_valid = 1'b1;
        op_a = v.a[i];
        op_b = v.b[i];
        check("issue_op_ready", 64'(op_ready), 64'd1);
        tick();
        op_valid = 1'b0;
        op_a = '0;
        op_b = '0;
      end
      check("drain_res_valid", 64'(res_valid), 64'd0);
      check("drain_op_ready", 64'(op_ready), 64'd0);
      tick();
      check("lat_res_valid", 64'(res_valid), 64'd1);
    end
    for (int h = 0; h < int'(v.hold); h++) begin
      check("hold_res_data", 64'(res_data), 64'(v.exp_data));
      check("hold_job_ready", 64'(job_ready), 64'd0);
      check("hold_busy", 64'(busy), 64'd1);
      check("hold_res_valid", 64'(res_valid), 64'd1);
      tick();
    end
    res_ready = 1'b1;
    check("res_data", 64'(res_data), 64'(v.exp_data));
    check("res_ovf", 64'(res_ovf), 64'(v.exp_ovf));
    check("res_valid", 64'(res_valid), 64'd1);
    tick();
    res_ready = 1'b0;
    check("idle_job_ready", 64'(job_ready), 64'd1);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_res_valid", 64'(res_valid), 64'd0);
  endtask

  vec_t tbl[10];

  initial begin
    vec_t v;
    logic [31:0] ed;
    logic        eo;
    int          mode;

    tbl[0] = mk(3, 32'd10, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 0, 0, 0, 32'd78, 1'b0);
    tbl[1] = mk(3, 32'd10, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 2, 3, 0, 32'd78, 1'b0);
    tbl[2] = mk(2, 32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd0, 16'd0,
                0, 0, 0, 32'hFFFF_FFFF, 1'b1);
    tbl[3] = mk(1, 32'd0, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 0, 0, 0, 32'd1, 1'b0);
    tbl[4] = mk(0, 32'd5, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 0, 0, 0, 32'd5, 1'b0);
    tbl[5] = mk(3, 32'd10, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 0, 0, 4, 32'd78, 1'b0);
    tbl[6] = mk(2, 32'hFFFF_FFFE, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0,
                0, 1, 0, 32'hFFFF_FFFF, 1'b0);
    tbl[7] = mk(2, 32'hFFFF_FFFE, 16'd1, 16'd1, 16'd1, 16'd1, 16'd0, 16'd0,
                0, 0, 1, 32'hFFFF_FFFF, 1'b1);
    tbl[8] = mk(1, 32'hFFFF_FFFF, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0,
                1, 0, 0, 32'hFFFF_FFFF, 1'b1);
    tbl[9] = mk(3, 32'd0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                0, 2, 2, 32'hFFFF_FFFF, 1'b1);

    rst = 1'b1;
    job_valid = 1'b0; job_len = '0; job_bias = '0;
    op_valid = 1'b0; op_a = '0; op_b = '0;
    res_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_data", 64'(res_data), 64'd0);
    check("rst_res_ovf", 64'(res_ovf), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_job_ready", 64'(job_ready), 64'd1);
    check("rst_op_ready", 64'(op_ready), 64'd0);

    for (int i = 0; i < 10; i++) begin
      run_job(tbl[i]);
    end

    // Reset after the first of three pairs discards the job.
    job_valid = 1'b1; job_len = 16'd3; job_bias = 32'd10;
    tick();
    job_valid = 1'b0;
    op_valid = 1'b1; op_a = 16'd2; op_b = 16'd3;
    tick();
    op_valid = 1'b0; op_a = '0; op_b = '0;
    check("mid_busy_before_rst", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_res_valid", 64'(res_valid), 64'd0);
    check("mid_rst_job_ready", 64'(job_ready), 64'd1);
    check("mid_rst_op_ready", 64'(op_ready), 64'd0);
    run_job(mk(1, 32'd0, 16'd3, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0, 0, 0, 0, 32'd12, 1'b0));

    // Randomized jobs against the reference model.
    for (int j = 0; j < 40; j++) begin
      v = '0;
      v.len = 16'($urandom_range(0, 6));
      v.bias = ($urandom_range(0, 3) == 0) ? (32'hFFF0_0000 | 32'($urandom_range(0, 32'hFFFFF)))
                                           : 32'($urandom);
      mode = int'($urandom_range(0, 2));
      for (int i = 0; i < 8; i++) begin
        case (mode)
          0:       begin v.a[i] = 16'($urandom); v.b[i] = 16'($urandom); end
          1:       begin v.a[i] = 16'($urandom_range(0, 255)); v.b[i] = 16'($urandom_range(0, 255)); end
          default: begin v.a[i] = 16'hFFFF - 16'($urandom_range(0, 3)); v.b[i] = 16'hFFFF; end
        endcase
      end
      v.gap_pre = 4'($urandom_range(0, 2));
      v.gap_mid = 4'($urandom_range(0, 2));
      v.hold    = 4'($urandom_range(0, 3));
      ref_model(v, ed, eo);
      v.exp_data = ed;
      v.exp_ovf  = eo;
      run_job(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
